fifo_rr_arbiter: RTL

//  Round-robin, packet-locked arbiter draining N per-port input FIFOs (tie_fifo instances) onto one router output link.

---
 rtl/noc_pkg.sv | 29 ++
 rtl/fifo_rr_arbiter_rr_pick.sv | 43 ++++
 rtl/fifo_rr_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : noc_pkg                                                     |
// | Purpose : Shared flit-format constants, arbiter state encodings and   |
// |           helpers for the router output-port arbiter.                 |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package noc_pkg;

  // HEAD and TAIL flags live at the top of every flit. The offsets are
  // counted down from the MSB so they hold for any flit width.
  localparam int HEAD_FROM_MSB = 0;
  localparam int TAIL_FROM_MSB = 1;

  // Default downstream buffer depth.
  localparam int CREDIT_MAX_DEF = 62;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Port index after v, wrapping from n-1 back to 0.
  function automatic int next_port(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rr_arbiter_rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : rr_pick                                                     |
// | Purpose : Combinational N-way rotating-priority picker. Searches req  |
// |           starting at ptr, wrapping N_PORTS-1 -> 0, and returns the   |
// |           first requester.                                            |
// | Ports   : req    in  N_PORTS   request vector                         |
// |           ptr    in  PORT_BITS highest-priority index (< N_PORTS)     |
// |           onehot out N_PORTS   one-hot winner (zero if none)          |
// |           idx    out PORT_BITS winner index (zero if none)            |
// |           any    out 1         at least one request present           |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module rr_pick #(
  parameter int N_PORTS   = 4,
  parameter int PORT_BITS = 2
) (
  input  logic [N_PORTS-1:0]   req,
  input  logic [PORT_BITS-1:0] ptr,
  output logic [N_PORTS-1:0]   onehot,
  output logic [PORT_BITS-1:0] idx,
  output logic                 any
);

  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      j = int'(ptr) + k;
      if (j >= N_PORTS) j = j - N_PORTS;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = PORT_BITS'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : fifo_rr_arbiter                                             |
// | Purpose : Round-robin, packet-locked arbiter draining N input FIFOs   |
// |           onto one output link with credit-based flow control.        |
// | Ports   : clk, reset (sync, active-high), ON (global enable)          |
// |           fifo_empty/fifo_data  per-FIFO status and front flit        |
// |           fifo_rdEn             one-hot-or-zero pop strobe (comb)     |
// |           flit_out/flit_valid/grant_id  registered link output        |
// |           credit_in             downstream freed one slot             |
// |           credits/credit_err    credit count and sticky overflow flag |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module fifo_rr_arbiter
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int N_PORTS     = 4,
  parameter int PORT_BITS   = 2,
  parameter int CREDIT_MAX  = CREDIT_MAX_DEF,
  parameter int CREDIT_BITS = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ON,
  input  logic [N_PORTS-1:0]           fifo_empty,
  input  logic [N_PORTS*DATA_WIDTH-1:0] fifo_data,
  output logic [N_PORTS-1:0]           fifo_rdEn,
  output logic [DATA_WIDTH-1:0]        flit_out,
  output logic                         flit_valid,
  output logic [PORT_BITS-1:0]         grant_id,
  input  logic                         credit_in,
  output logic [CREDIT_BITS-1:0]       credits,
  output logic                         credit_err
);

  localparam int HEAD_BIT = DATA_WIDTH - 1 - HEAD_FROM_MSB;
  localparam int TAIL_BIT = DATA_WIDTH - 1 - TAIL_FROM_MSB;
  localparam logic [CREDIT_BITS-1:0] CREDIT_FULL = CREDIT_BITS'(CREDIT_MAX);

  arb_state_e                state_q,      state_d;
  logic [PORT_BITS-1:0]      lock_id_q,    lock_id_d;
  logic [PORT_BITS-1:0]      rr_ptr_q,     rr_ptr_d;
  logic [CREDIT_BITS-1:0]    credits_q,    credits_d;
  logic [DATA_WIDTH-1:0]     flit_q,       flit_d;
  logic                      flit_valid_q, flit_valid_d;
  logic [PORT_BITS-1:0]      grant_id_q,   grant_id_d;
  logic                      credit_err_q, credit_err_d;

  logic [N_PORTS-1:0]        pick_onehot;
  logic [PORT_BITS-1:0]      pick_idx;
  logic                      pick_any;

  logic [N_PORTS-1:0]        lock_onehot;
  logic [N_PORTS-1:0]        sel_onehot;
  logic [PORT_BITS-1:0]      sel;
  logic                      sel_ready;
  logic                      send;
  logic [DATA_WIDTH-1:0]     sel_flit;
  logic                      is_head;
  logic                      is_tail;

  rr_pick #(
    .N_PORTS   (N_PORTS),
    .PORT_BITS (PORT_BITS)
  ) u_rr_pick (
    .req    (~fifo_empty),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Source selection: free search while idle, pinned to the packet owner
  // while locked so packets are never interleaved on the link.
  always_comb begin
    lock_onehot            = '0;
    lock_onehot[lock_id_q] = 1'b1;
    if (state_q == ARB_LOCKED) begin
      sel        = lock_id_q;
      sel_onehot = lock_onehot;
      sel_ready  = ~fifo_empty[lock_id_q];
    end else begin
      sel        = pick_idx;
      sel_onehot = pick_onehot;
      sel_ready  = pick_any;
    end
    // Reset gating keeps the pop strobe quiet while reset is asserted.
    send      = ON & ~reset & (credits_q != '0) & sel_ready;
    fifo_rdEn = send ? sel_onehot : '0;
    sel_flit  = fifo_data[sel*DATA_WIDTH +: DATA_WIDTH];
    is_head   = sel_flit[HEAD_BIT];
    is_tail   = sel_flit[TAIL_BIT];
  end

  always_comb begin
    state_d      = state_q;
    lock_id_d    = lock_id_q;
    rr_ptr_d     = rr_ptr_q;
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    flit_d       = flit_q;
    grant_id_d   = grant_id_q;
    flit_valid_d = send;

    if (send) begin
      flit_d     = sel_flit;
      grant_id_d = sel;
      if (state_q == ARB_LOCKED) begin
        if (is_tail) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = PORT_BITS'(next_port(int'(lock_id_q), N_PORTS));
        end
      end else if (is_head && !is_tail) begin
        state_d   = ARB_LOCKED;
        lock_id_d = sel;
      end else begin
        // Single-flit packet, or a stray body flit at the front of an idle
        // port: forwarded as-is and arbitration moves on.
        rr_ptr_d = PORT_BITS'(next_port(int'(sel), N_PORTS));
      end
    end

    // Credit updates proceed even with ON low so returning credits are
    // never lost.
    if (send && !credit_in) begin
      credits_d = credits_q - CREDIT_BITS'(1);
    end else if (credit_in && !send) begin
      if (credits_q == CREDIT_FULL) begin
        credit_err_d = 1'b1;
      end else begin
        credits_d = credits_q + CREDIT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      lock_id_q    <= '0;
      rr_ptr_q     <= '0;
      credits_q    <= CREDIT_FULL;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      grant_id_q   <= '0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_id_q    <= lock_id_d;
      rr_ptr_q     <= rr_ptr_d;
      credits_q    <= credits_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
      grant_id_q   <= grant_id_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign flit_out   = flit_q;
  assign flit_valid = flit_valid_q;
  assign grant_id   = grant_id_q;
  assign credits    = credits_q;
  assign credit_err = credit_err_q;

endmodule
`default_nettype wire
